seletor_destino_pipe: RTL and testbench

Parametrised successor to the single-cycle RegDst multiplexer for the pipelined MIPS datapath. It selects the write-destination register from rt, rd or a fixed link register, based on a 2-bit mode. It carries the selected destination and a write-valid bit through a configurable number of pipeline stages, with stall and flush support. Decode-stage hazard detection gets combinational conflict flags that compare the current source registers against every in-flight destination.

---
 rtl/seletor_destino_pipe.sv | 95 +++++++++
 tb/tb_seletor_destino_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seletor_destino_pipe.sv
// Write-destination select (rt / rd / link) for the pipelined datapath, with a
// stall/flush-aware destination pipeline and decode-stage conflict detection.
module seletor_destino_pipe #(
  parameter int REG_BITS = 5,
  parameter int STAGES   = 3,
  parameter int LINK_REG = 31
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [REG_BITS-1:0] instrucao20_16,
  input  logic [REG_BITS-1:0] instrucao15_11,
  input  logic [1:0]          controle,
  input  logic                escreve_reg,
  input  logic                avanca,
  input  logic                descarta,
  input  logic [REG_BITS-1:0] fonte_a,
  input  logic [REG_BITS-1:0] fonte_b,
  output logic [REG_BITS-1:0] escrita_registrador,
  output logic [REG_BITS-1:0] destino_wb,
  output logic                escrita_wb,
  output logic                conflito_a,
  output logic                conflito_b,
  output logic [STAGES-1:0]   estagio_a,
  output logic [STAGES-1:0]   estagio_b
);

  logic [STAGES-1:0]               valid_q, valid_d;
  logic [STAGES-1:0][REG_BITS-1:0] dest_q, dest_d;

  logic [REG_BITS-1:0] sel;
  logic                cand_valid;
  logic [REG_BITS-1:0] cand_dest;

  always_comb begin
    sel = '0;
    case (controle)
      2'b00:   sel = instrucao20_16;
      2'b01:   sel = instrucao15_11;
      2'b10:   sel = REG_BITS'(LINK_REG);
      default: sel = '0;
    endcase
    // register 0 is a sink, so it is never tracked as a destination
    cand_valid = escreve_reg & ~descarta & (controle != 2'b11) & (sel != '0);
    cand_dest  = cand_valid ? sel : '0;
  end

  always_comb begin
    valid_d = valid_q;
    dest_d  = dest_q;
    if (avanca) begin
      valid_d[0] = cand_valid;
      dest_d[0]  = cand_dest;
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        dest_d[i]  = dest_q[i-1];
      end
    end else if (descarta) begin
      valid_d[0] = 1'b0;
      dest_d[0]  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dest_q  <= '0;
    end else begin
      valid_q <= valid_d;
      dest_q  <= dest_d;
    end
  end

  // oldest-to-youngest scan so the youngest match wins
  always_comb begin
    estagio_a = '0;
    estagio_b = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (valid_q[i] && dest_q[i] == fonte_a && fonte_a != '0) begin
        estagio_a    = '0;
        estagio_a[i] = 1'b1;
      end
      if (valid_q[i] && dest_q[i] == fonte_b && fonte_b != '0) begin
        estagio_b    = '0;
        estagio_b[i] = 1'b1;
      end
    end
    conflito_a = |estagio_a;
    conflito_b = |estagio_b;
  end

  assign escrita_registrador = sel;
  assign destino_wb          = dest_q[STAGES-1];
  assign escrita_wb          = valid_q[STAGES-1];

endmodule

// File: tb/tb_seletor_destino_pipe.sv
// Self-checking bench: a 3-stage instance and a 1-stage/link-30 instance share
// stimulus and are compared against queue-based reference models.
module tb_seletor_destino_pipe;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] rt, rd, fa, fb;
  logic [1:0] ctl;
  logic       we, av, fl;

  logic [4:0] esc3, dwb3, esc1, dwb1;
  logic       ewb3, ca3, cb3, ewb1, ca1, cb1;
  logic [2:0] ea3, eb3;
  logic [0:0] ea1, eb1;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  seletor_destino_pipe #(.REG_BITS(5), .STAGES(3), .LINK_REG(31)) dut (
    .clock(clock), .reset(reset), .instrucao20_16(rt), .instrucao15_11(rd),
    .controle(ctl), .escreve_reg(we), .avanca(av), .descarta(fl),
    .fonte_a(fa), .fonte_b(fb), .escrita_registrador(esc3),
    .destino_wb(dwb3), .escrita_wb(ewb3), .conflito_a(ca3), .conflito_b(cb3),
    .estagio_a(ea3), .estagio_b(eb3));

  seletor_destino_pipe #(.REG_BITS(5), .STAGES(1), .LINK_REG(30)) dut1 (
    .clock(clock), .reset(reset), .instrucao20_16(rt), .instrucao15_11(rd),
    .controle(ctl), .escreve_reg(we), .avanca(av), .descarta(fl),
    .fonte_a(fa), .fonte_b(fb), .escrita_registrador(esc1),
    .destino_wb(dwb1), .escrita_wb(ewb1), .conflito_a(ca1), .conflito_b(cb1),
    .estagio_a(ea1), .estagio_b(eb1));

  typedef struct {bit v; logic [4:0] d;} ent_t;
  typedef ent_t ent_q_t[$];

  ent_q_t m3, m1;

  function automatic logic [4:0] sel_of(logic [1:0] c, logic [4:0] t, logic [4:0] r,
                                        logic [4:0] link);
    if (c == 2'd0) return t;
    if (c == 2'd1) return r;
    if (c == 2'd2) return link;
    return 5'd0;
  endfunction

  function automatic ent_t cand(logic [4:0] link);
    ent_t e;
    logic [4:0] s = sel_of(ctl, rt, rd, link);
    e.v = we && !fl && ctl != 2'd3 && s != 5'd0;
    e.d = e.v ? s : 5'd0;
    return e;
  endfunction

  function automatic ent_q_t advance(ent_q_t q, ent_t c, bit a, bit f);
    ent_q_t r = q;
    if (a) begin
      r.push_front(c);
      void'(r.pop_back());
    end else if (f) begin
      r[0].v = 1'b0;
      r[0].d = 5'd0;
    end
    return r;
  endfunction

  function automatic ent_q_t empty_pipe(int n);
    ent_q_t r;
    ent_t z;
    z.v = 1'b0;
    z.d = 5'd0;
    for (int i = 0; i < n; i++) r.push_back(z);
    return r;
  endfunction

  // index of the youngest matching stage, -1 if none
  function automatic int youngest(ent_q_t q, logic [4:0] src);
    if (src == 5'd0) return -1;
    for (int i = 0; i < q.size(); i++)
      if (q[i].v && q[i].d == src) return i;
    return -1;
  endfunction

  task automatic drive(logic [1:0] c, logic [4:0] t, logic [4:0] r, bit w,
                       bit a, bit f, logic [4:0] sa, logic [4:0] sb);
    ctl = c; rt = t; rd = r; we = w; av = a; fl = f; fa = sa; fb = sb;
  endtask

  // one cycle: combinational checks before the edge, pipeline checks after it
  task automatic step(logic [1:0] c, logic [4:0] t, logic [4:0] r, bit w,
                      bit a, bit f, logic [4:0] sa, logic [4:0] sb);
    int ia, ib;
    logic [2:0] xa, xb;
    drive(c, t, r, w, a, f, sa, sb);
    #1;
    ia = youngest(m3, sa);
    ib = youngest(m3, sb);
    xa = (ia < 0) ? 3'b000 : 3'(1 << ia);
    xb = (ib < 0) ? 3'b000 : 3'(1 << ib);
    tests++;
    if (esc3 !== sel_of(c, t, r, 5'd31) || esc1 !== sel_of(c, t, r, 5'd30)) begin
      failed++;
      $display("FAIL sel: got %0d/%0d want %0d/%0d", esc3, esc1,
               sel_of(c, t, r, 5'd31), sel_of(c, t, r, 5'd30));
    end
    tests++;
    if (ca3 !== (ia >= 0) || cb3 !== (ib >= 0) || ea3 !== xa || eb3 !== xb) begin
      failed++;
      $display("FAIL conflict3: got ca=%b cb=%b ea=%b eb=%b want ca=%b cb=%b ea=%b eb=%b",
               ca3, cb3, ea3, eb3, ia >= 0, ib >= 0, xa, xb);
    end
    tests++;
    if (ca1 !== (youngest(m1, sa) >= 0) || cb1 !== (youngest(m1, sb) >= 0)) begin
      failed++;
      $display("FAIL conflict1: got ca=%b cb=%b", ca1, cb1);
    end
    @(posedge clock);
    m3 = advance(m3, cand(5'd31), a, f);
    m1 = advance(m1, cand(5'd30), a, f);
    #1;
    tests++;
    if (dwb3 !== m3[2].d || ewb3 !== m3[2].v || dwb1 !== m1[0].d || ewb1 !== m1[0].v) begin
      failed++;
      $display("FAIL wb: got %0d/%b %0d/%b want %0d/%b %0d/%b", dwb3, ewb3, dwb1, ewb1,
               m3[2].d, m3[2].v, m1[0].d, m1[0].v);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(2'd3, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    m3 = empty_pipe(3);
    m1 = empty_pipe(1);
  endtask

  task automatic test_reset();
    step(2'd0, 5'd4, 0, 1, 1, 0, 0, 0);
    step(2'd0, 5'd6, 0, 1, 1, 0, 0, 0);
    step(2'd0, 5'd8, 0, 1, 1, 0, 6, 0);
    drive(2'd3, 0, 0, 0, 0, 0, 5'd6, 0);
    #1;
    tests++;
    if (ca3 !== 1'b1 || ewb3 !== 1'b1 || dwb3 !== 5'd4) begin
      failed++;
      $display("FAIL pre_reset: got ca=%b wb=%0d/%b want 1 4/1", ca3, dwb3, ewb3);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (ewb3 !== 1'b0 || dwb3 !== 5'd0 || ca3 !== 1'b0 || ea3 !== 3'b000) begin
      failed++;
      $display("FAIL async_reset: got wb=%0d/%b ca=%b ea=%b want 0/0 0 000",
               dwb3, ewb3, ca3, ea3);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    m3 = empty_pipe(3);
    m1 = empty_pipe(1);
  endtask

  task automatic test_mode();
    logic [4:0] gd[4];
    bit         gv[4];
    logic [4:0] wd[4] = '{5'd5, 5'd9, 5'd31, 5'd0};
    bit         wv[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] we_sel[4] = '{5'd5, 5'd9, 5'd31, 5'd0};
    for (int k = 0; k < 4; k++) begin
      drive(2'(k), 5'd5, 5'd9, 1, 1, 0, 0, 0);
      #1;
      tests++;
      if (esc3 !== we_sel[k]) begin
        failed++;
        $display("FAIL mode_sel%0d: got %0d want %0d", k, esc3, we_sel[k]);
      end
      step(2'(k), 5'd5, 5'd9, 1, 1, 0, 0, 0);
      if (k == 2) begin gd[0] = dwb3; gv[0] = ewb3; end
      if (k == 3) begin gd[1] = dwb3; gv[1] = ewb3; end
    end
    for (int k = 0; k < 2; k++) begin
      step(2'd3, 0, 0, 0, 1, 0, 0, 0);
      gd[2+k] = dwb3;
      gv[2+k] = ewb3;
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (gd[k] !== wd[k] || gv[k] !== wv[k]) begin
        failed++;
        $display("FAIL mode_wb%0d: got %0d/%b want %0d/%b", k, gd[k], gv[k], wd[k], wv[k]);
      end
    end
  endtask

  task automatic test_reg_zero();
    step(2'd1, 5'd3, 5'd0, 1, 1, 0, 0, 0);
    step(2'd3, 0, 0, 0, 1, 0, 0, 0);
    step(2'd3, 0, 0, 0, 1, 0, 0, 0);
    tests++;
    if (ewb3 !== 1'b0 || ca3 !== 1'b0) begin
      failed++;
      $display("FAIL reg_zero: got wb_valid=%b ca=%b want 0 0", ewb3, ca3);
    end
  endtask

  task automatic test_stall_flush();
    int edges = 1;
    int hit = -1;
    step(2'd0, 5'd7, 0, 1, 1, 0, 0, 0);
    step(2'd3, 0, 0, 0, 0, 0, 0, 0);
    step(2'd3, 0, 0, 0, 0, 0, 0, 0);
    edges += 2;
    for (int k = 0; k < 6 && hit < 0; k++) begin
      step(2'd3, 0, 0, 0, 1, 0, 0, 0);
      edges++;
      if (ewb3 && dwb3 == 5'd7) hit = edges;
    end
    tests++;
    if (hit != 5) begin
      failed++;
      $display("FAIL stall_latency: got %0d edges want 5", hit);
    end
    hit = 0;
    step(2'd0, 5'd7, 0, 1, 1, 0, 0, 0);
    step(2'd3, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(2'd3, 0, 0, 0, 1, 0, 0, 0);
      if (ewb3 && dwb3 == 5'd7) hit = 1;
    end
    tests++;
    if (hit != 0) begin
      failed++;
      $display("FAIL flush: got dest 7 at wb want never");
    end
  endtask

  task automatic test_hazard_priority();
    step(2'd0, 5'd12, 0, 1, 1, 0, 0, 0);
    step(2'd3, 0, 0, 0, 1, 0, 0, 0);
    step(2'd1, 0, 5'd12, 1, 1, 0, 0, 0);
    drive(2'd3, 0, 0, 0, 0, 0, 5'd12, 5'd3);
    #1;
    tests++;
    if (ca3 !== 1'b1 || ea3 !== 3'b001 || cb3 !== 1'b0 || eb3 !== 3'b000) begin
      failed++;
      $display("FAIL hazard_prio: got ca=%b ea=%b cb=%b eb=%b want 1 001 0 000",
               ca3, ea3, cb3, eb3);
    end
  endtask

  task automatic test_link_one_stage();
    step(2'd2, 5'd1, 5'd2, 1, 1, 0, 0, 0);
    tests++;
    if (dwb1 !== 5'd30 || ewb1 !== 1'b1) begin
      failed++;
      $display("FAIL link_1stage: got %0d/%b want 30/1", dwb1, ewb1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++)
      step(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
  endtask

  initial begin
    drive(2'd3, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #2;
    tests++;
    if (ewb3 !== 1'b0 || dwb3 !== 5'd0 || ewb1 !== 1'b0 || ca3 !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: got wb=%0d/%b wb1=%b ca=%b", dwb3, ewb3, ewb1, ca3);
    end
    do_reset();
    test_reset();
    test_mode();
    test_reg_zero();
    test_stall_flush();
    test_hazard_priority();
    test_link_one_stage();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
